// File: rtl/div_usign_4.sv
// ============================================================================
// Module   : div_usign_4
// Brief    : 4-bit unsigned restoring divider, one quotient bit per clock,
//            with start/done handshake and divide-by-zero flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_usign_4 (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [3:0] r_a;
    logic [3:0] r_q;
    logic [3:0] r_m;
    logic [1:0] r_count;

    logic [3:0] w_a_nxt;
    logic [3:0] w_q_nxt;
    logic [3:0] w_m_nxt;
    logic [1:0] w_count_nxt;
    logic [3:0] w_quot_nxt;
    logic [3:0] w_rem_nxt;
    logic       w_dbz_nxt;

    logic [4:0] w_p;
    logic [3:0] w_diff;
    logic       w_borrow;
    logic [3:0] w_a_iter;
    logic [3:0] w_q_iter;

    // Partial remainder never exceeds 2*M-1, so the low nibble of P-M is exact
    // whenever the subtraction does not borrow.
    assign w_p      = {r_a, r_q[3]};
    assign w_borrow = (w_p < {1'b0, r_m});
    assign w_diff   = w_p[3:0] - r_m;
    assign w_a_iter = w_borrow ? w_p[3:0] : w_diff;
    assign w_q_iter = {r_q[2:0], ~w_borrow};

    assign busy = (r_state == S_CALC);
    assign done = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_q_nxt     = r_q;
        w_m_nxt     = r_m;
        w_count_nxt = r_count;
        w_quot_nxt  = quotient;
        w_rem_nxt   = remainder;
        w_dbz_nxt   = div_by_zero;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (divisor != 4'd0) begin
                        w_a_nxt     = 4'd0;
                        w_q_nxt     = dividend;
                        w_m_nxt     = divisor;
                        w_count_nxt = 2'd0;
                        w_state_nxt = S_CALC;
                    end else begin
                        w_quot_nxt  = 4'hF;
                        w_rem_nxt   = dividend;
                        w_dbz_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_CALC: begin
                w_a_nxt     = w_a_iter;
                w_q_nxt     = w_q_iter;
                w_count_nxt = r_count + 2'd1;
                if (r_count == 2'd3) begin
                    w_quot_nxt  = w_q_iter;
                    w_rem_nxt   = w_a_iter;
                    w_dbz_nxt   = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a         <= 4'd0;
            r_q         <= 4'd0;
            r_m         <= 4'd0;
            r_count     <= 2'd0;
            quotient    <= 4'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else begin
            r_a         <= w_a_nxt;
            r_q         <= w_q_nxt;
            r_m         <= w_m_nxt;
            r_count     <= w_count_nxt;
            quotient    <= w_quot_nxt;
            remainder   <= w_rem_nxt;
            div_by_zero <= w_dbz_nxt;
        end
    end

endmodule

`default_nettype wire

// File: doc/div_usign_4.md
# div_usign_4

Sequential 4-bit unsigned divider: the inverse of the 4-bit add/subtract datapath. It computes quotient and remainder by restoring shift-and-subtract, one quotient bit per clock. It sits beside the combinational adder/subtractor in the chapter-4 arithmetic set and uses a start/done handshake toward the surrounding control.

## Interface
- No parameters; operand width fixed at 4 bits.
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse/level; sampled on rising edge only when not busy
- dividend  input  4  unsigned dividend, sampled with accepted start
- divisor  input  4  unsigned divisor, sampled with accepted start
- quotient  output  4  registered result, valid while done=1, held until next completion
- remainder  output  4  registered result, same validity as quotient
- busy  output  1  high while iterating
- done  output  1  one-cycle completion strobe
- div_by_zero  output  1  registered flag for the last completed operation (divisor = 0)

## Operation
- Reset (asynchronous, any state): state IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; internal A=0, Q=0, M=0, count=0.
- States: IDLE, CALC, DONE.
- IDLE or DONE with start=1:
  - divisor≠0: load A←0, Q←dividend, M←divisor, count←0; go to CALC.
  - divisor=0: go to DONE directly with quotient←4'b1111, remainder←dividend, div_by_zero←1.
- start=0 in DONE: go to IDLE. start=0 in IDLE: remain in IDLE.
- CALC, each cycle:
  - P = {A, Q[3]} (5 bits).
  - D = P − {1'b0, M}, computed 6 bits wide with borrow.
  - No borrow: A←D[3:0], Q←{Q[2:0],1}.
  - Borrow: A←P[3:0], Q←{Q[2:0],0}.
  - P never exceeds 2·M−1, so P[3:0] is exact on restore and D[3:0] is exact on subtract.
- count increments each CALC cycle. On the fourth iteration (count=3), the iteration result is written to quotient/remainder, div_by_zero←0, and the state goes to DONE.
- start while in CALC is ignored; operands are not resampled.
- quotient, remainder and div_by_zero change only on entry to DONE; they hold otherwise.
- busy = (state==CALC); done = (state==DONE). Both are decoded from the state register, so there are no combinational input-to-output paths.

## Timing
- start accepted at edge k (divisor≠0): busy=1 after k. Iterations run at edges k+1..k+4. done=1, busy=0, results valid after k+4. done=0 after k+5 unless a new start is accepted at k+5.
- Latency is 4 cycles from accept to done; throughput is 1 operation per 5 cycles. Back-to-back: start held high in DONE is accepted at k+5, and done stays low for that cycle.
- Divide by zero: done=1 after edge k (1-cycle latency); busy is never asserted.
- Reset asserted mid-CALC clears everything immediately; no partial result is ever presented. After reset deasserts, the first start is accepted on the next qualifying edge.
- Invariants at done: dividend = quotient·divisor + remainder, and remainder < divisor, for divisor≠0.

## Test plan
- 13 / 3, start at edge k → busy for 4 cycles, done after k+4, quotient=4, remainder=1, div_by_zero=0.
- 15 / 1 → quotient=15, remainder=0. 2 / 3 → quotient=0, remainder=2. 15 / 15 → quotient=1, remainder=0.
- 7 / 0 → done after the accepting edge, quotient=15, remainder=7, div_by_zero=1, busy never high. A following 9 / 2 clears the flag and gives quotient=4, remainder=1.
- Start 12 / 5, then pulse start with 15 / 1 mid-CALC → the second request is ignored; result is quotient=2, remainder=2.
- Start 14 / 4 and assert reset two cycles later → all outputs 0 immediately, state IDLE. A fresh 14 / 4 then gives quotient=3, remainder=2.
- Exhaustive sweep over all 256 operand pairs → every done matches the reference quotient/remainder, and done is high for exactly one cycle per accepted start.
